nios_onchip_mem_initiator: RTL and testbench
============================================

Name: nios_onchip_mem_initiator

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave: 32-bit data, 13-bit word address, 5120 words, read data valid one clock after address.
- Executes fill (pattern write) and verify (read and compare) commands over a contiguous word range.
- Used for boot-time memory init and built-in memory test ahead of the Nios core.
- Sits between a small command source (CSR or control FSM) and the RAM's s1/s2 port.

Parameters:
- ADDR_W, 13, word address width.
- DEPTH, 5120, number of addressable words.
- READ_LATENCY, 1, clocks from read address to valid mem_readdata (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  high when IDLE; a command is accepted on cmd_valid & cmd_ready.
- cmd_op  in  1  0 = fill, 1 = verify.
- cmd_addr  in  ADDR_W  start word address.
- cmd_count  in  ADDR_W+1  number of words.
- cmd_seed  in  32  pattern seed.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- cmd_err  out  1  one-cycle pulse; range rejected.
- err_count  out  16  verify mismatch count, saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  4  constant 4'hF.
- mem_chipselect  out  1  access strobe.
- mem_write  out  1  write enable.
- mem_writedata  out  32  write data.
- mem_readdata  in  32  RAM read data.
- mem_clken  out  1  RAM clock enable; constant 1.

Behaviour:
- Reset values:
  - busy, done, cmd_err, mem_chipselect, mem_write = 0.
  - err_count, first_err_addr, mem_address, mem_writedata = 0.
  - cmd_ready = 1.
- FSM states: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE, on command accept:
  - If cmd_addr + cmd_count > DEPTH: pulse cmd_err next cycle, stay IDLE, no access, status unchanged.
  - If cmd_count = 0: go to FINISH, no access.
  - Otherwise: clear err_count and first_err_addr; load index = 0 and pattern = seed; go to WRITE (op=0) or READ (op=1); busy = 1 from the next cycle.
- WRITE:
  - One write per cycle: chipselect = 1, write = 1, address = cmd_addr + index, writedata = pattern(index).
  - First access occurs the cycle after accept.
  - After index = count-1, go to FINISH.
- READ:
  - One read per cycle: chipselect = 1, write = 0; back-to-back, no bubbles.
  - Per issued read, a READ_LATENCY-deep shift pipe carries a valid bit, the address, and the expected pattern.
  - After the last read, go to DRAIN.
- Compare: when a pipe entry exits, compare mem_readdata with the expected pattern.
  - On mismatch, increment err_count (saturates at 16'hFFFF).
  - On the first mismatch of the command, capture its address into first_err_addr.
- DRAIN: hold with chipselect = 0 until the pipe is empty (READ_LATENCY cycles), then go to FINISH.
- FINISH: pulse done for one cycle, busy = 0, return to IDLE. err_count and first_err_addr hold until the next accepted command.
- Total latency, accept to done:
  - fill: count + 1 cycles.
  - verify: count + READ_LATENCY + 1 cycles.
- Pattern (default): pattern(i) = seed + i, 32-bit wrap-around.
- Addresses never wrap; the range check above guarantees this.
- mem_chipselect and mem_write are low in every non-access cycle.
- cmd_valid while busy is ignored.
- Reset mid-operation: aborts on the next edge, pipe cleared, no further access, no done pulse.

Optional Feature:
- Macro: NIOS_MEMINIT_LFSR_EN.
- Defined:
  - Pattern is a 32-bit Galois LFSR, taps 0x80200003, advanced once per word.
  - A seed of 0 is replaced by 1.
  - pattern(0) = seed.
- Undefined: incrementing pattern as in Behaviour; no LFSR logic synthesized.

Test Plan:
1. Fill addr=0x010, count=4, seed=0xA5A50000:
   - writes to 0x010..0x013 with data 0xA5A50000..0xA5A50003 in 4 consecutive cycles after accept.
   - done pulses at cycle 5; busy low after.
2. Verify same range against a RAM model:
   - 4 back-to-back reads; done at cycle 4 + READ_LATENCY + 1.
   - err_count = 0.
3. Verify with the model word at 0x012 corrupted to 0xDEADBEEF, plus a second corruption at 0x013:
   - err_count = 2; first_err_addr = 0x012.
4. cmd_addr = 5118, cmd_count = 3:
   - cmd_err pulses; no chipselect; busy stays 0; previous err_count retained.
   - cmd_count = 0: done pulses at cycle 1, no access.
5. Assert reset during a 100-word fill at word 37:
   - chipselect = 0 from the next cycle; all outputs at reset values; no done.
   - A new command accepted afterwards runs normally.
6. Repeat scenarios 2 and 3 with READ_LATENCY = 3, and scenario 1 with NIOS_MEMINIT_LFSR_EN defined and seed 0:
   - verify sequence matches the reference LFSR model, starting at 0x00000001.

Source files
------------

// File: rtl/nios_onchip_mem_initiator_if.sv
// Avalon-MM bus between the memory initiator and the single-port on-chip RAM.
// Parameter:
//   ADDR_W - word address width
// master modport: address, byteenable, chipselect, write, writedata, clken out; readdata in.
// slave modport : the mirror image of master.
interface nios_onchip_mem_initiator_if #(
  parameter int unsigned ADDR_W = 13
);
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_clken;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/nios_onchip_mem_initiator.sv
// Avalon-MM master that fills (pattern write) or verifies (read and compare)
// a contiguous word range of the on-chip RAM, for boot-time init and memory test.
// Optional macro NIOS_MEMINIT_LFSR_EN: pattern is a 32-bit Galois LFSR
// (taps 0x80200003, seed 0 replaced by 1) instead of seed + index.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake, ready only while idle
//   cmd_op                - 0 fill, 1 verify
//   cmd_addr/cmd_count    - start word address and word count
//   cmd_seed              - pattern seed
//   busy, done, cmd_err   - status; done and cmd_err are one-cycle pulses
//   err_count             - saturating verify mismatch count
//   first_err_addr        - address of the first mismatch of the last command
//   mem                   - RAM bus (master modport)
module nios_onchip_mem_initiator #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DEPTH        = 5120,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic [31:0]       cmd_seed,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  nios_onchip_mem_initiator_if.master mem
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned SUM_W  = ADDR_W + 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERR_W  = 16;
  localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);
`ifdef NIOS_MEMINIT_LFSR_EN
  localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h8020_0003;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   idx_q, idx_n;     // index of the word currently on the bus
  logic [CNT_W-1:0]   last_q, last_n;   // count - 1
  logic [DATA_W-1:0]  pat_q, pat_n;     // pattern of the word currently on the bus
  logic [LAT_W-1:0]   drain_q, drain_n;

  logic               cmd_ready_n, busy_n, done_n, cmd_err_n;
  logic [ERR_W-1:0]   err_n;
  logic [ADDR_W-1:0]  first_n;
  logic               cs_n, wr_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [DATA_W-1:0]  wdata_n;
  logic [DATA_W-1:0]  seed0;
  logic [SUM_W-1:0]   range_sum;

  // Read-tracking pipe: one entry per issued read, exits when its data is valid
  logic               pipe_v [READ_LATENCY];
  logic [ADDR_W-1:0]  pipe_a [READ_LATENCY];
  logic [DATA_W-1:0]  pipe_p [READ_LATENCY];
  logic               push;
  logic               cmp_miss;

  function automatic logic [DATA_W-1:0] pat_step(input logic [DATA_W-1:0] p);
`ifdef NIOS_MEMINIT_LFSR_EN
    pat_step = {1'b0, p[DATA_W-1:1]} ^ (p[0] ? LFSR_TAPS : DATA_W'(0));
`else
    pat_step = p + DATA_W'(1);
`endif
  endfunction

  assign mem.mem_byteenable = 4'hF;
  assign mem.mem_clken      = 1'b1;

  assign push     = mem.mem_chipselect & ~mem.mem_write;
  assign cmp_miss = pipe_v[READ_LATENCY-1] && (mem.mem_readdata != pipe_p[READ_LATENCY-1]);

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    last_n      = last_q;
    pat_n       = pat_q;
    drain_n     = drain_q;
    cmd_ready_n = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    cmd_err_n   = 1'b0;
    err_n       = err_count;
    first_n     = first_err_addr;
    cs_n        = 1'b0;
    wr_n        = 1'b0;
    addr_n      = mem.mem_address;
    wdata_n     = mem.mem_writedata;
`ifdef NIOS_MEMINIT_LFSR_EN
    seed0       = (cmd_seed == DATA_W'(0)) ? DATA_W'(1) : cmd_seed;
`else
    seed0       = cmd_seed;
`endif
    range_sum   = SUM_W'(cmd_addr) + SUM_W'(cmd_count);

    // err_count == 0 means no mismatch seen yet in this command
    if (cmp_miss) begin
      if (err_count != {ERR_W{1'b1}}) err_n = err_count + ERR_W'(1);
      if (err_count == ERR_W'(0))     first_n = pipe_a[READ_LATENCY-1];
    end

    case (state_q)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          if (range_sum > SUM_W'(DEPTH)) begin
            cmd_err_n = 1'b1;
          end else if (cmd_count == CNT_W'(0)) begin
            state_n     = FINISH;
            cmd_ready_n = 1'b0;
            done_n      = 1'b1;
          end else begin
            state_n     = cmd_op ? READ : WRITE;
            cmd_ready_n = 1'b0;
            busy_n      = 1'b1;
            err_n       = ERR_W'(0);
            first_n     = ADDR_W'(0);
            idx_n       = CNT_W'(0);
            last_n      = cmd_count - CNT_W'(1);
            pat_n       = seed0;
            cs_n        = 1'b1;
            wr_n        = ~cmd_op;
            addr_n      = cmd_addr;
            if (!cmd_op) wdata_n = seed0;
          end
        end
      end
      WRITE, READ: begin
        if (idx_q == last_q) begin
          if (state_q == WRITE) begin
            state_n = FINISH;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = DRAIN;
            drain_n = LAT_W'(0);
          end
        end else begin
          idx_n  = idx_q + CNT_W'(1);
          pat_n  = pat_step(pat_q);
          cs_n   = 1'b1;
          wr_n   = (state_q == WRITE);
          addr_n = mem.mem_address + ADDR_W'(1);
          if (state_q == WRITE) wdata_n = pat_step(pat_q);
        end
      end
      DRAIN: begin
        if (drain_q == LAT_W'(READ_LATENCY - 1)) begin
          state_n = FINISH;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          drain_n = drain_q + LAT_W'(1);
        end
      end
      FINISH: begin
        state_n     = IDLE;
        cmd_ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      idx_q              <= '0;
      last_q             <= '0;
      pat_q              <= '0;
      drain_q            <= '0;
      cmd_ready          <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      cmd_err            <= 1'b0;
      err_count          <= '0;
      first_err_addr     <= '0;
      mem.mem_chipselect <= 1'b0;
      mem.mem_write      <= 1'b0;
      mem.mem_address    <= '0;
      mem.mem_writedata  <= '0;
    end else begin
      state_q            <= state_n;
      idx_q              <= idx_n;
      last_q             <= last_n;
      pat_q              <= pat_n;
      drain_q            <= drain_n;
      cmd_ready          <= cmd_ready_n;
      busy               <= busy_n;
      done               <= done_n;
      cmd_err            <= cmd_err_n;
      err_count          <= err_n;
      first_err_addr     <= first_n;
      mem.mem_chipselect <= cs_n;
      mem.mem_write      <= wr_n;
      mem.mem_address    <= addr_n;
      mem.mem_writedata  <= wdata_n;
    end
  end

  // Pipe valid bits, cleared by reset so an aborted command leaves nothing behind
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= push;
      for (int i = 1; i < READ_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Pipe payload: address and expected pattern of each issued read
  always_ff @(posedge clk) begin
    pipe_a[0] <= mem.mem_address;
    pipe_p[0] <= pat_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_p[i] <= pipe_p[i-1];
    end
  end

endmodule

// File: tb/tb_nios_onchip_mem_initiator.sv
// Testbench for nios_onchip_mem_initiator: two instances (read latency 1 and 3),
// each with a RAM model, driven by a table of commands plus reset sequences.
module tb_nios_onchip_mem_initiator;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 5120;

  typedef struct {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [31:0]       seed;
    logic              lat3;
    logic              corrupt;
    logic              exp_cmd_err;
    int                exp_lat;
    logic [15:0]       exp_errs;
    logic [ADDR_W-1:0] exp_first;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic v1, v3;
  logic c_op;
  logic [ADDR_W-1:0] c_addr;
  logic [ADDR_W:0]   c_count;
  logic [31:0]       c_seed;

  logic ready1, busy1, done1, cerr1, ready3, busy3, done3, cerr3;
  logic [15:0] ec1, ec3;
  logic [ADDR_W-1:0] fe1, fe3;

  logic sel3, bad_en;
  int n_total, n_pass;

  nios_onchip_mem_initiator_if #(.ADDR_W(ADDR_W)) m1 ();
  nios_onchip_mem_initiator_if #(.ADDR_W(ADDR_W)) m3 ();

  nios_onchip_mem_initiator #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(ready1), .cmd_op(c_op),
    .cmd_addr(c_addr), .cmd_count(c_count), .cmd_seed(c_seed), .busy(busy1),
    .done(done1), .cmd_err(cerr1), .err_count(ec1), .first_err_addr(fe1), .mem(m1)
  );

  nios_onchip_mem_initiator #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(ready3), .cmd_op(c_op),
    .cmd_addr(c_addr), .cmd_count(c_count), .cmd_seed(c_seed), .busy(busy3),
    .done(done3), .cmd_err(cerr3), .err_count(ec3), .first_err_addr(fe3), .mem(m3)
  );

  always #5 clk = ~clk;

  // Observed signals of the instance under test
  logic o_ready, o_busy, o_done, o_cerr, o_cs, o_wr;
  logic [15:0] o_ec;
  logic [ADDR_W-1:0] o_fe, o_addr;
  logic [31:0] o_wd;
  assign o_ready = sel3 ? ready3 : ready1;
  assign o_busy  = sel3 ? busy3  : busy1;
  assign o_done  = sel3 ? done3  : done1;
  assign o_cerr  = sel3 ? cerr3  : cerr1;
  assign o_ec    = sel3 ? ec3    : ec1;
  assign o_fe    = sel3 ? fe3    : fe1;
  assign o_cs    = sel3 ? m3.mem_chipselect : m1.mem_chipselect;
  assign o_wr    = sel3 ? m3.mem_write      : m1.mem_write;
  assign o_addr  = sel3 ? m3.mem_address    : m1.mem_address;
  assign o_wd    = sel3 ? m3.mem_writedata  : m1.mem_writedata;

  // RAM models; bad_en corrupts the words at 0x012 and 0x013 on read
  logic [31:0] ram1 [8192];
  logic [31:0] ram3 [8192];
  logic [31:0] r3_s1, r3_s2;

  function automatic logic [31:0] rd_val(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    if (bad_en && (a == 13'h012 || a == 13'h013)) return 32'hDEAD_BEEF;
    return d;
  endfunction

  always @(posedge clk) begin
    if (m1.mem_chipselect && m1.mem_write) ram1[m1.mem_address] <= m1.mem_writedata;
    m1.mem_readdata <= rd_val(m1.mem_address, ram1[m1.mem_address]);
    if (m3.mem_chipselect && m3.mem_write) ram3[m3.mem_address] <= m3.mem_writedata;
    r3_s1 <= rd_val(m3.mem_address, ram3[m3.mem_address]);
    r3_s2 <= r3_s1;
    m3.mem_readdata <= r3_s2;
  end

  function automatic logic [31:0] exp_pat(input logic [31:0] seed, input int k);
    logic [31:0] p;
`ifdef NIOS_MEMINIT_LFSR_EN
    p = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < k; i++) p = {1'b0, p[31:1]} ^ (p[0] ? 32'h8020_0003 : 32'h0);
`else
    p = seed + 32'(k);
`endif
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int acc, ev_cyc;
    logic got_err;
    sel3   = v.lat3;
    bad_en = v.corrupt;
    @(negedge clk);
    c_op = v.op; c_addr = v.addr; c_count = v.count; c_seed = v.seed;
    if (v.lat3) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0; v3 = 1'b0;
    acc = 0; ev_cyc = 0; got_err = 1'b0;
    for (int c = 1; c <= v.exp_lat + 20; c++) begin
      @(negedge clk);
      if (c == 1) chk($sformatf("v%0d_busy_c1", id), 32'(o_busy),
                      32'(!v.exp_cmd_err && v.count != 0));
      if (o_cs) begin
        chk($sformatf("v%0d_addr%0d", id, acc), 32'(o_addr), 32'(v.addr) + 32'(acc));
        chk($sformatf("v%0d_wr%0d", id, acc), 32'(o_wr), 32'(!v.op));
        if (!v.op) chk($sformatf("v%0d_wdata%0d", id, acc), o_wd, exp_pat(v.seed, acc));
        acc++;
      end
      if (o_done || o_cerr) begin
        got_err = o_cerr;
        ev_cyc  = c;
        break;
      end
    end
    chk($sformatf("v%0d_event_cycle", id), 32'(ev_cyc), 32'(v.exp_lat));
    chk($sformatf("v%0d_cmd_err", id), 32'(got_err), 32'(v.exp_cmd_err));
    chk($sformatf("v%0d_accesses", id), 32'(acc), v.exp_cmd_err ? 32'd0 : 32'(v.count));
    chk($sformatf("v%0d_busy_end", id), 32'(o_busy), 32'd0);
    chk($sformatf("v%0d_err_count", id), 32'(o_ec), 32'(v.exp_errs));
    chk($sformatf("v%0d_first_err", id), 32'(o_fe), 32'(v.exp_first));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", id), 32'(o_done | o_cerr), 32'd0);
    chk($sformatf("v%0d_ready_after", id), 32'(o_ready), 32'd1);
    chk($sformatf("v%0d_cs_after", id), 32'(o_cs), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"},    32'(o_cs), 32'd0);
    chk({tag, "_wr"},    32'(o_wr), 32'd0);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_done"},  32'(o_done), 32'd0);
    chk({tag, "_cerr"},  32'(o_cerr), 32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_addr"},  32'(o_addr), 32'd0);
    chk({tag, "_wdata"}, o_wd, 32'd0);
    chk({tag, "_ec"},    32'(o_ec), 32'd0);
    chk({tag, "_fe"},    32'(o_fe), 32'd0);
  endtask

  vec_t vecs [13];

  initial begin
    int c37;
    logic seen;
    n_total = 0; n_pass = 0;
    sel3 = 1'b0; bad_en = 1'b0;
    v1 = 1'b0; v3 = 1'b0; c_op = 1'b0; c_addr = '0; c_count = '0; c_seed = '0;

    //          op    addr      count      seed           lat3  corr  cerr  lat  errs    first
    vecs[0]  = '{1'b0, 13'h010, 14'd4,    32'hA5A5_0000, 1'b0, 1'b0, 1'b0, 5,  16'd0, 13'h000};
    vecs[1]  = '{1'b1, 13'h010, 14'd4,    32'hA5A5_0000, 1'b0, 1'b0, 1'b0, 6,  16'd0, 13'h000};
    vecs[2]  = '{1'b1, 13'h010, 14'd4,    32'hA5A5_0000, 1'b0, 1'b1, 1'b0, 6,  16'd2, 13'h012};
    vecs[3]  = '{1'b0, 13'd5118, 14'd3,   32'h0000_0000, 1'b0, 1'b0, 1'b1, 1,  16'd2, 13'h012};
    vecs[4]  = '{1'b0, 13'h100, 14'd0,    32'h0000_0000, 1'b0, 1'b0, 1'b0, 1,  16'd2, 13'h012};
    vecs[5]  = '{1'b0, 13'h010, 14'd4,    32'hA5A5_0000, 1'b1, 1'b0, 1'b0, 5,  16'd0, 13'h000};
    vecs[6]  = '{1'b1, 13'h010, 14'd4,    32'hA5A5_0000, 1'b1, 1'b0, 1'b0, 8,  16'd0, 13'h000};
    vecs[7]  = '{1'b1, 13'h010, 14'd4,    32'hA5A5_0000, 1'b1, 1'b1, 1'b0, 8,  16'd2, 13'h012};
    vecs[8]  = '{1'b0, 13'h020, 14'd4,    32'h0000_0000, 1'b0, 1'b0, 1'b0, 5,  16'd0, 13'h000};
    vecs[9]  = '{1'b1, 13'h020, 14'd4,    32'h0000_0000, 1'b0, 1'b0, 1'b0, 6,  16'd0, 13'h000};
    vecs[10] = '{1'b0, 13'd5116, 14'd4,   32'h0000_1234, 1'b0, 1'b0, 1'b0, 5,  16'd0, 13'h000};
    vecs[11] = '{1'b1, 13'd5116, 14'd4,   32'h0000_1234, 1'b0, 1'b0, 1'b0, 6,  16'd0, 13'h000};
    vecs[12] = '{1'b0, 13'h000, 14'd5121, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1,  16'd0, 13'h000};

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // Reset during a 100-word fill, at word 37
    @(negedge clk);
    c_op = 1'b0; c_addr = 13'h200; c_count = 14'd100; c_seed = 32'h0000_1000;
    v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    seen = 1'b0; c37 = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (o_cs && o_addr == 13'(13'h200 + 13'd37)) begin
        seen = 1'b1; c37 = c;
        break;
      end
    end
    chk("abort_word37_seen", 32'(seen), 32'd1);
    chk("abort_word37_cycle", 32'(c37), 32'd38);
    chk("abort_word37_data", o_wd, exp_pat(32'h0000_1000, 37));
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort_idle%0d_cs", c), 32'(o_cs), 32'd0);
      chk($sformatf("abort_idle%0d_done", c), 32'(o_done), 32'd0);
    end

    // Command table
    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
